regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb.sv | 214 +++++++++++++++++++++
 tb/tb_regfile_wb_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb.sv
// ---------------------------------------------------------------------------
// regfile_wb_arb
//
// Purpose:
//   Arbitrates the single register-file write port between the ALU (one
//   request per cycle, held upstream when refused) and the mul/div unit,
//   whose results are buffered in a small FIFO. The ALU normally wins. A
//   buffered result that keeps losing is eventually forced through. When the
//   FIFO is empty and the ALU is not writing, a mul/div result bypasses the
//   FIFO. The write port is registered, so a grant in cycle N appears in
//   cycle N+1. Writes to x0 are consumed without asserting wen.
//
// Parameters:
//   FIFO_DEPTH    mul/div result buffer entries (power of 2, 2..8)
//   STARVE_LIMIT  cycles a buffered head may lose before it is forced
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   alu_valid    ALU writeback request
//   alu_ready    ALU request accepted this cycle
//   alu_rd       ALU destination register
//   alu_data     ALU result
//   md_valid     mul/div result valid
//   md_ready     mul/div result accepted this cycle
//   md_rd        mul/div destination register
//   md_data      mul/div result
//   wen          register-file write enable (registered)
//   wsel         register-file write select (registered)
//   wdat         register-file write data (registered)
//   md_pending   FIFO holds at least one result
//   perf_collide (WB_PERF_CNT_EN only) cycles with ALU and mul/div contending
//   perf_force   (WB_PERF_CNT_EN only) forced FIFO-head grants
//
// Build option:
//   WB_PERF_CNT_EN  adds the two wrapping performance counters above.
// ---------------------------------------------------------------------------
module regfile_wb_arb #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        wen,
    output logic [4:0]  wsel,
    output logic [31:0] wdat,
    output logic        md_pending
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0] perf_collide,
    output logic [31:0] perf_force
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

    // FIFO storage and bookkeeping
    logic [4:0]       fifo_rd   [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve;
    logic [STV_W-1:0] starve_nxt;

    logic fifo_empty;
    logic fifo_full;
    logic forced;
    logic alu_grant;
    logic head_grant;
    logic md_accept;
    logic bypass;
    logic push;
    logic pop;

    logic        g_valid;
    logic [4:0]  g_rd;
    logic [31:0] g_data;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);

    // A head that has lost STARVE_LIMIT times in a row takes the port and
    // the ALU is refused for exactly that cycle; it retries the next cycle.
    assign forced     = !rst && !fifo_empty && (starve == STV_MAX);
    assign alu_ready  = !rst && !forced;
    assign alu_grant  = alu_valid && alu_ready;

    // The head wins whenever the ALU does not (forced implies no ALU grant).
    assign head_grant = !rst && !fifo_empty && !alu_grant;

    // A full FIFO can still take a result if the head leaves this cycle.
    assign md_ready   = !rst && (!fifo_full || head_grant);
    assign md_accept  = md_valid && md_ready;

    // Empty FIFO and idle port: send the mul/div result straight through.
    assign bypass     = fifo_empty && md_accept && !alu_grant;
    assign push       = md_accept && !bypass;
    assign pop        = head_grant;

    assign md_pending = !fifo_empty;

    always_comb begin
        g_valid = 1'b0;
        g_rd    = '0;
        g_data  = '0;
        if (head_grant) begin
            g_valid = 1'b1;
            g_rd    = fifo_rd[rd_ptr];
            g_data  = fifo_data[rd_ptr];
        end else if (alu_grant) begin
            g_valid = 1'b1;
            g_rd    = alu_rd;
            g_data  = alu_data;
        end else if (bypass) begin
            g_valid = 1'b1;
            g_rd    = md_rd;
            g_data  = md_data;
        end
    end

    // Starvation: only a head that actually lost to the ALU counts up.
    always_comb begin
        starve_nxt = starve;
        if (fifo_empty || head_grant) begin
            starve_nxt = '0;
        end else if (alu_grant && (starve != STV_MAX)) begin
            starve_nxt = starve + STV_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wen    <= 1'b0;
            wsel   <= '0;
            wdat   <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            starve <= '0;
        end else begin
            // x0 grants are consumed but never reach the register file.
            wen <= g_valid && (g_rd != 5'd0);
            if (g_valid) begin
                wsel <= g_rd;
                wdat <= g_data;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            starve <= starve_nxt;
        end
    end

    // Payload storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= md_rd;
            fifo_data[wr_ptr] <= md_data;
        end
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_collide <= '0;
            perf_force   <= '0;
        end else begin
            if (alu_valid && (!fifo_empty || md_valid)) begin
                perf_collide <= perf_collide + 32'd1;
            end
            if (forced) begin
                perf_force <= perf_force + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        md_pending;
`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_collide;
    logic [31:0] perf_force;
`endif

    always #5 clk = ~clk;

    regfile_wb_arb #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_rd     (md_rd),
        .md_data   (md_data),
        .wen       (wen),
        .wsel      (wsel),
        .wdat      (wdat),
        .md_pending(md_pending)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_collide(perf_collide),
        .perf_force  (perf_force)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of buffered results plus a loss counter.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          starve   = 0;
    bit          wp_known = 0;
    logic        m_wen    = 1'b0;
    logic [4:0]  m_wsel   = '0;
    logic [31:0] m_wdat   = '0;
    bit          alu_took = 0;
    bit          md_took  = 0;
    int unsigned m_coll   = 0;
    int unsigned m_force  = 0;

    // Check one cycle against the model, advance the model, then clock.
    task automatic step();
        bit   forced, alu_g, head_g, md_acc, byp, gv, m_ar, m_mr;
        ent_t g;
        forced = 0; alu_g = 0; head_g = 0; m_ar = 0; m_mr = 0;
        md_acc = 0; byp = 0; gv = 0; g = '0;
        #1;
        if (!rst) begin
            forced = (q.size() > 0) && (starve == LIMIT);
            m_ar   = !forced;
            alu_g  = alu_valid && m_ar;
            head_g = (q.size() > 0) && !alu_g;
            m_mr   = (q.size() < DEPTH) || head_g;
        end
        chk("alu_ready", alu_ready, m_ar);
        chk("md_ready", md_ready, m_mr);
        if (wp_known) begin
            chk("md_pending", md_pending, q.size() > 0);
            chk("wen", wen, m_wen);
            if (m_wen) begin
                chk("wsel", wsel, m_wsel);
                chk("wdat", wdat, m_wdat);
            end
        end
        alu_took = !rst && alu_valid && m_ar;
        md_took  = !rst && md_valid && m_mr;
        if (rst) begin
            q.delete();
            starve   = 0;
            m_wen    = 1'b0;
            m_wsel   = '0;
            m_wdat   = '0;
            m_coll   = 0;
            m_force  = 0;
            wp_known = 1;
        end else begin
            md_acc = md_valid && m_mr;
            byp    = (q.size() == 0) && md_acc && !alu_g;
            gv     = 1;
            if (head_g)     g = q[0];
            else if (alu_g) g = {alu_rd, alu_data};
            else if (byp)   g = {md_rd, md_data};
            else            gv = 0;
            if (alu_valid && (q.size() > 0 || md_valid)) m_coll++;
            if (forced) m_force++;
            if (q.size() == 0 || head_g) starve = 0;
            else if (starve < LIMIT)     starve++;
            m_wen = gv && (g.rd != 5'd0);
            if (gv) begin
                m_wsel = g.rd;
                m_wdat = g.data;
            end
            if (head_g) void'(q.pop_front());
            if (md_acc && !byp) q.push_back({md_rd, md_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        md_valid  = 1'b0;
    endtask

    logic [4:0] md_order[$];

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        md_valid = 0; md_rd = 0; md_data = 0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_wsel", wsel, 0);
        chk("rst_wdat", wdat, 0);
        rst = 1'b0;

        // Single ALU write lands one cycle later, for one cycle.
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        chk("t21_wen", wen, 1);
        chk("t21_wsel", wsel, 5);
        chk("t21_wdat", wdat, 32'hDEADBEEF);
        step();
        chk("t21_once", wen, 0);

        // ALU and mul/div together: ALU first, buffered result next.
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        md_valid = 1; md_rd = 7; md_data = 32'h77;
        step();
        idle_inputs();
        chk("t22_wsel_n1", wsel, 3);
        chk("t22_pend_n1", md_pending, 1);
        step();
        chk("t22_wsel_n2", wsel, 7);
        chk("t22_pend_n2", md_pending, 0);

        // Starvation: head forced on the fifth contention cycle.
        alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
        md_valid = 1; md_rd = 9; md_data = 32'h900;
        step();
        md_valid = 0;
        for (int i = 1; i <= 5; i++) begin
            if (alu_took) begin
                alu_rd = 5'(10 + i);
                alu_data = 32'(i);
            end
            #1;
            chk("t23_ready", alu_ready, (i == 5) ? 0 : 1);
            step();
        end
        chk("t23_head_wsel", wsel, 9);
        chk("t23_head_wen", wen, 1);
        step();
        chk("t23_alu_retry", wsel, 15);
        idle_inputs();
        step();

        // Three mul/div results against a continuous ALU stream.
        begin
            int n_md = 0;
            bit seen_full = 0;
            alu_rd = 1; alu_data = 32'hA000_0001; alu_valid = 1;
            for (int c = 0; c < 24; c++) begin
                if (alu_took) begin
                    alu_rd = 5'(1 + (c % 15));
                    alu_data = 32'hA000_0000 + 32'(c);
                end
                if (n_md < 3) begin
                    md_valid = 1; md_rd = 5'(20 + n_md); md_data = 32'hB000_0000 + 32'(n_md);
                end else begin
                    md_valid = 0;
                end
                if (c >= 18) alu_valid = 0;
                if (n_md == 2 && !seen_full) begin
                    #1;
                    chk("t24_full", md_ready, 0);
                    seen_full = 1;
                end
                step();
                if (md_took) n_md++;
                if (wen && wsel >= 5'd20) md_order.push_back(wsel);
            end
            chk("t24_accepts", n_md, 3);
            chk("t24_writes", md_order.size(), 3);
            for (int k = 0; k < 3 && k < md_order.size(); k++)
                chk("t24_order", md_order[k], 20 + k);
        end
        idle_inputs();
        step();

        // x0 destinations: bypass and buffered.
        md_valid = 1; md_rd = 0; md_data = 32'h1234;
        step();
        idle_inputs();
        chk("t25_byp_wen", wen, 0);
        chk("t25_byp_pend", md_pending, 0);
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        md_valid = 1; md_rd = 0; md_data = 32'h1234;
        step();
        idle_inputs();
        step();
        chk("t25_fifo_wen", wen, 0);
        chk("t25_fifo_pend", md_pending, 0);

        // Reset with two buffered entries.
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        md_valid = 1; md_rd = 12; md_data = 32'hC0;
        step();
        alu_rd = 5; alu_data = 32'h55; md_rd = 13; md_data = 32'hD0;
        step();
        idle_inputs();
        chk("t26_full", md_pending, 1);
        rst = 1;
        step();
        chk("t26_wen", wen, 0);
        chk("t26_pend", md_pending, 0);
        rst = 0;
        step();
        chk("t26_no_stale1", wen, 0);
        step();
        chk("t26_no_stale2", wen, 0);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!alu_valid || alu_took) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!md_valid || md_took) begin
                md_valid = ($urandom_range(0, 99) < 40);
                md_rd    = 5'($urandom_range(0, 31));
                md_data  = $urandom;
            end
            step();
        end
        rst = 0;
        idle_inputs();
        step();
`ifdef WB_PERF_CNT_EN
        chk("perf_collide", perf_collide, m_coll);
        chk("perf_force", perf_force, m_force);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
